// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder/subtractor with start/done handshake,
// round-to-nearest-even and overflow/underflow/invalid flags.
module fp_add_seq #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    localparam int W     = 1 + EXP_W + FRAC_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic         ovf,
    output logic         unf,
    output logic         nv,
    output logic [2:0]   state_dbg
);
    // Handshake: start is sampled only in IDLE and the operands are captured on
    // that edge; busy stays high until the edge leaving DONE; done pulses for
    // exactly one cycle with y and the flags valid from that cycle on.

    localparam int SW = FRAC_W + 4;  // {hidden, frac, guard, round, sticky}
    localparam int AW = SW + 1;      // plus carry
    localparam int EW = EXP_W + 1;   // room for exponent growth past all-ones

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t         state;
    logic [W-1:0]   a_r, b_r;
    logic [SW-1:0]  big_sig, small_sig;
    logic [AW-1:0]  sum_r;
    logic [EW-1:0]  exp_r;
    logic           sign_r, eff_sub;

    assign state_dbg = state;

    // Operand decode, special cases and alignment of the captured operands.
    logic              sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
    logic [EXP_W-1:0]  ea, eb, big_exp_c, shift_c;
    logic [FRAC_W-1:0] fa, fb;
    logic [SW-1:0]     sig_a, sig_b, small_raw, shifted, small_al_c;
    logic              lost, special_c, special_nv;
    logic [W-1:0]      special_y;

    always_comb begin
        sa = a_r[W-1];
        sb = b_r[W-1];
        ea = a_r[W-2:FRAC_W];
        eb = b_r[W-2:FRAC_W];
        fa = a_r[FRAC_W-1:0];
        fb = b_r[FRAC_W-1:0];

        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = (ea == '1) && (fa == '0);
        b_inf  = (eb == '1) && (fb == '0);
        a_nan  = (ea == '1) && (fa != '0);
        b_nan  = (eb == '1) && (fb != '0);

        // Denormals are flushed: a zero exponent yields a zero significand.
        sig_a = {!a_zero, {FRAC_W{!a_zero}} & fa, 3'b000};
        sig_b = {!b_zero, {FRAC_W{!b_zero}} & fb, 3'b000};
        a_big = (ea > eb) || ((ea == eb) && (fa >= fb));

        big_exp_c = a_big ? ea : eb;
        shift_c   = a_big ? (ea - eb) : (eb - ea);
        small_raw = a_big ? sig_b : sig_a;
        shifted   = small_raw >> shift_c;
        lost      = |(small_raw & ~({SW{1'b1}} << shift_c));
        small_al_c = {shifted[SW-1:1], shifted[0] | lost};

        special_c  = 1'b1;
        special_nv = 1'b0;
        special_y  = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
            special_y  = QNAN;
            special_nv = 1'b1;
        end else if (a_inf) begin
            special_y = {sa, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (b_inf) begin
            special_y = {sb, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else if (a_zero && b_zero) begin
            special_y = {sa & sb, {(W-1){1'b0}}};
        end else begin
            special_c = 1'b0;
        end
    end

    // Round to nearest even on guard/round/sticky, with same-cycle renormalise.
    logic              round_up, ovf_c;
    logic [FRAC_W+1:0] mant_rnd;
    logic [EW-1:0]     exp_rnd;
    logic [FRAC_W-1:0] frac_rnd;

    always_comb begin
        round_up = sum_r[2] & (sum_r[1] | sum_r[0] | sum_r[3]);
        mant_rnd = {1'b0, sum_r[SW-1:3]} + (FRAC_W+2)'(round_up);
        exp_rnd  = exp_r + EW'(mant_rnd[FRAC_W+1]);
        frac_rnd = mant_rnd[FRAC_W+1] ? mant_rnd[FRAC_W:1] : mant_rnd[FRAC_W-1:0];
        ovf_c    = (exp_rnd >= {1'b0, {EXP_W{1'b1}}});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            y         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            nv        <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            big_sig   <= '0;
            small_sig <= '0;
            sum_r     <= '0;
            exp_r     <= '0;
            sign_r    <= 1'b0;
            eff_sub   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= {b[W-1] ^ op, b[W-2:0]};
                        ovf   <= 1'b0;
                        unf   <= 1'b0;
                        nv    <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (special_c) begin
                        y     <= special_y;
                        nv    <= special_nv;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        big_sig   <= a_big ? sig_a : sig_b;
                        small_sig <= small_al_c;
                        exp_r     <= {1'b0, big_exp_c};
                        sign_r    <= a_big ? sa : sb;
                        eff_sub   <= sa ^ sb;
                        state     <= S_ADD;
                    end
                end
                S_ADD: begin
                    sum_r <= eff_sub ? ({1'b0, big_sig} - {1'b0, small_sig})
                                     : ({1'b0, big_sig} + {1'b0, small_sig});
                    state <= S_NORM;
                end
                S_NORM: begin
                    if (sum_r == '0) begin
                        y     <= '0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (sum_r[AW-1]) begin
                        sum_r <= {1'b0, sum_r[AW-1:2], sum_r[1] | sum_r[0]};
                        exp_r <= exp_r + 1'b1;
                    end else if (!sum_r[SW-1]) begin
                        // Cancellation that would reach exponent 0 flushes to zero.
                        if (exp_r == EW'(1)) begin
                            y     <= '0;
                            unf   <= 1'b1;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            sum_r <= sum_r << 1;
                            exp_r <= exp_r - 1'b1;
                        end
                    end else begin
                        state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (ovf_c) begin
                        y <= {sign_r, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                    end else begin
                        y <= {sign_r, exp_rnd[EXP_W-1:0], frac_rnd};
                    end
                    ovf   <= ovf_c;
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
